// File: rtl/wb_slave_mux.sv
`default_nettype none
// ============================================================================
//  Module   : wb_slave_mux
//  Purpose  : Wishbone slave-side interconnect for the user project area.
//             Decodes the master bus into N_SLAVES address windows and
//             forwards one transaction at a time to the selected slave.
//             Unmapped addresses get an error response. Each forwarded
//             transaction has an ack timeout. An internal CSR window holds
//             sticky error status, the last error address, and masked,
//             edge-latched IRQ aggregation onto irq_o.
//
//  Ports    : wb_clk_i, wb_rst_i       clock, async active-high reset
//             wbs_cyc_i/stb_i/we_i     master cycle, strobe, write enable
//             wbs_sel_i[3:0]           byte selects (CSR writes: full word only)
//             wbs_adr_i/dat_i[31:0]    master address, write data
//             wbs_ack_o, wbs_dat_o     registered ack and read data
//             s_cyc_o/s_stb_o[N-1:0]   one-hot slave cycle/strobe
//             s_ack_i[N-1:0]           slave acks
//             s_dat_i[32*N-1:0]        packed slave read data
//             s_irq_i[N-1:0]           level IRQs from slaves
//             irq_o                    registered OR of pending & mask
//
//  CSR map  : 0x0 STATUS   [0] unmapped, [1] timeout (W1C), [10:8] last idx
//             0x4 ERR_ADDR (RO)
//             0x8 IRQ_MASK (RW)
//             0xC IRQ_PEND (W1C, set has priority over clear)
//
//  Revision : 1.0  initial release
// ============================================================================
module wb_slave_mux #(
   parameter int                    N_SLAVES       = 4,
   parameter logic [32*N_SLAVES-1:0] BASE_ADDRS    = {32'h3300_0000, 32'h3200_0000,
                                                      32'h3100_0000, 32'h3000_0000},
   parameter logic [31:0]           ADDR_MASK      = 32'hFFFF_F000,
   parameter logic [31:0]           CSR_BASE       = 32'h30FF_F000,
   parameter int                    TIMEOUT_CYCLES = 255
) (
   input  logic                     wb_clk_i,
   input  logic                     wb_rst_i,
   input  logic                     wbs_cyc_i,
   input  logic                     wbs_stb_i,
   input  logic                     wbs_we_i,
   input  logic [3:0]               wbs_sel_i,
   input  logic [31:0]              wbs_adr_i,
   input  logic [31:0]              wbs_dat_i,
   output logic                     wbs_ack_o,
   output logic [31:0]              wbs_dat_o,
   output logic [N_SLAVES-1:0]      s_cyc_o,
   output logic [N_SLAVES-1:0]      s_stb_o,
   input  logic [N_SLAVES-1:0]      s_ack_i,
   input  logic [32*N_SLAVES-1:0]   s_dat_i,
   input  logic [N_SLAVES-1:0]      s_irq_i,
   output logic                     irq_o
);

   localparam logic [15:0] TO_LAST       = 16'(TIMEOUT_CYCLES - 1);
   localparam logic [31:0] DATA_UNMAPPED = 32'hBAD0_ADD0;
   localparam logic [31:0] DATA_TIMEOUT  = 32'hDEAD_DEAD;
   localparam logic [3:0]  OFF_STATUS    = 4'h0;
   localparam logic [3:0]  OFF_ERR_ADDR  = 4'h4;
   localparam logic [3:0]  OFF_IRQ_MASK  = 4'h8;
   localparam logic [3:0]  OFF_IRQ_PEND  = 4'hC;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_FWD  = 2'd1,
      ST_ACK  = 2'd2
   } state_t;

   state_t              state;
   state_t              state_nxt;

   // Transaction context
   logic [2:0]          idx;          // selected slave, also STATUS[10:8]
   logic [31:0]         adr_q;        // address of the forwarded transaction
   logic [15:0]         cnt;          // cycles spent in FWD

   // CSR state
   logic                sts_unmapped;
   logic                sts_timeout;
   logic [31:0]         err_addr;
   logic [N_SLAVES-1:0] irq_mask;
   logic [N_SLAVES-1:0] irq_pend;
   logic [N_SLAVES-1:0] irq_prev;

   // FSM control strobes
   logic                start_fwd;
   logic                csr_access;
   logic                unmapped;
   logic                capture;
   logic                timeout;

   // ------------------------------------------------------------------------
   // Address decode
   // ------------------------------------------------------------------------
   logic                req;
   logic                csr_hit;
   logic [N_SLAVES-1:0] win_hit;
   logic                any_hit;
   logic [2:0]          hit_idx;

   assign req     = wbs_cyc_i & wbs_stb_i;
   assign csr_hit = (wbs_adr_i & ADDR_MASK) == (CSR_BASE & ADDR_MASK);

   genvar gi;
   generate
      for (gi = 0; gi < N_SLAVES; gi++) begin : g_win
         assign win_hit[gi] = (wbs_adr_i & ADDR_MASK) ==
                              (BASE_ADDRS[32*gi +: 32] & ADDR_MASK);
      end
   endgenerate

   // Lowest index wins when windows overlap: scan downward so the last
   // assignment made is the lowest matching index.
   always_comb begin
      any_hit = 1'b0;
      hit_idx = 3'd0;
      for (int i = N_SLAVES - 1; i >= 0; i--) begin
         if (win_hit[i]) begin
            any_hit = 1'b1;
            hit_idx = 3'(i);
         end
      end
   end

   // ------------------------------------------------------------------------
   // Selected-slave return path; acks from other slaves never reach the FSM
   // ------------------------------------------------------------------------
   logic        sel_ack;
   logic [31:0] sel_dat;

   always_comb begin
      sel_ack = 1'b0;
      sel_dat = 32'd0;
      for (int i = 0; i < N_SLAVES; i++) begin
         if (idx == 3'(i)) begin
            sel_ack = s_ack_i[i];
            sel_dat = s_dat_i[32*i +: 32];
         end
      end
   end

   // ------------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------------
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // ------------------------------------------------------------------------
   // FSM: next state and outputs. The slave strobes are decoded from the
   // state register so an asynchronous reset drops them immediately; they
   // are also gated by the master cycle so an abort releases the slave in
   // the same cycle the master lets go.
   // ------------------------------------------------------------------------
   always_comb begin
      state_nxt  = state;
      s_cyc_o    = '0;
      s_stb_o    = '0;
      start_fwd  = 1'b0;
      csr_access = 1'b0;
      unmapped   = 1'b0;
      capture    = 1'b0;
      timeout    = 1'b0;

      case (state)
         ST_IDLE: begin
            if (req) begin
               if (csr_hit) begin
                  csr_access = 1'b1;
                  state_nxt  = ST_ACK;
               end else if (any_hit) begin
                  start_fwd  = 1'b1;
                  state_nxt  = ST_FWD;
               end else begin
                  unmapped   = 1'b1;
                  state_nxt  = ST_ACK;
               end
            end
         end

         ST_FWD: begin
            if (!wbs_cyc_i) begin
               // Master abandoned the cycle: no ack, no error recorded.
               state_nxt = ST_IDLE;
            end else begin
               for (int i = 0; i < N_SLAVES; i++) begin
                  if (idx == 3'(i)) begin
                     s_cyc_o[i] = 1'b1;
                     s_stb_o[i] = 1'b1;
                  end
               end
               if (sel_ack) begin
                  capture   = 1'b1;
                  state_nxt = ST_ACK;
               end else if (cnt == TO_LAST) begin
                  timeout   = 1'b1;
                  state_nxt = ST_ACK;
               end
            end
         end

         ST_ACK: begin
            state_nxt = ST_IDLE;
         end

         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // CSR access decode
   // ------------------------------------------------------------------------
   logic [3:0]          csr_off;
   logic                csr_wr;
   logic [31:0]         csr_rdata;
   logic [N_SLAVES-1:0] pend_clr;
   logic [N_SLAVES-1:0] irq_rise;

   assign csr_off = wbs_adr_i[3:0];
   assign csr_wr  = csr_access & wbs_we_i & (wbs_sel_i == 4'hF);

   always_comb begin
      csr_rdata = 32'd0;
      case (csr_off)
         OFF_STATUS:   csr_rdata = {21'd0, idx, 6'd0, sts_timeout, sts_unmapped};
         OFF_ERR_ADDR: csr_rdata = err_addr;
         OFF_IRQ_MASK: csr_rdata = 32'(irq_mask);
         OFF_IRQ_PEND: csr_rdata = 32'(irq_pend);
         default:      csr_rdata = 32'd0;
      endcase
   end

   assign pend_clr = (csr_wr && csr_off == OFF_IRQ_PEND) ? wbs_dat_i[N_SLAVES-1:0] : '0;
   assign irq_rise = s_irq_i & ~irq_prev;

   // Only the low bits of the write data land in CSRs.
   logic unused_dat;
   assign unused_dat = ^wbs_dat_i[31:N_SLAVES];

   // ------------------------------------------------------------------------
   // Datapath and CSR registers
   // ------------------------------------------------------------------------
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         wbs_ack_o    <= 1'b0;
         wbs_dat_o    <= 32'd0;
         irq_o        <= 1'b0;
         idx          <= 3'd0;
         adr_q        <= 32'd0;
         cnt          <= 16'd0;
         sts_unmapped <= 1'b0;
         sts_timeout  <= 1'b0;
         err_addr     <= 32'd0;
         irq_mask     <= '0;
         irq_pend     <= '0;
         irq_prev     <= '0;
      end else begin
         // Ack is high exactly for the cycle spent in ACK.
         wbs_ack_o <= (state_nxt == ST_ACK);

         if (state == ST_FWD) begin
            cnt <= cnt + 16'd1;
         end else begin
            cnt <= 16'd0;
         end

         if (start_fwd) begin
            idx   <= hit_idx;
            adr_q <= wbs_adr_i;
         end

         if (csr_access) begin
            wbs_dat_o <= csr_rdata;
         end else if (unmapped) begin
            wbs_dat_o <= DATA_UNMAPPED;
         end else if (capture) begin
            wbs_dat_o <= sel_dat;
         end else if (timeout) begin
            wbs_dat_o <= DATA_TIMEOUT;
         end

         // Error capture and STATUS W1C never coincide: errors are raised
         // only outside a CSR access.
         if (unmapped) begin
            sts_unmapped <= 1'b1;
            err_addr     <= wbs_adr_i;
         end else if (timeout) begin
            sts_timeout  <= 1'b1;
            err_addr     <= adr_q;
         end else if (csr_wr && csr_off == OFF_STATUS) begin
            sts_unmapped <= sts_unmapped & ~wbs_dat_i[0];
            sts_timeout  <= sts_timeout  & ~wbs_dat_i[1];
         end

         if (csr_wr && csr_off == OFF_IRQ_MASK) begin
            irq_mask <= wbs_dat_i[N_SLAVES-1:0];
         end

         // A rising edge in the same cycle as a W1C keeps the bit set.
         irq_prev <= s_irq_i;
         irq_pend <= (irq_pend & ~pend_clr) | irq_rise;
         irq_o    <= |(irq_pend & irq_mask);
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_wb_slave_mux.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wb_slave_mux
//  Purpose  : Self-checking bench for wb_slave_mux. Expected ack data is
//             queued when a master transaction starts and compared when the
//             DUT acks. Slaves are modelled with programmable wait states.
//  Revision : 1.0  initial release
// ============================================================================
module tb_wb_slave_mux;

   localparam int NS = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic              cyc, stb, we;
   logic [3:0]        sel;
   logic [31:0]       adr, wdat;
   logic              ack;
   logic [31:0]       rdat;
   logic [NS-1:0]     s_cyc, s_stb, s_ack, s_irq;
   logic [32*NS-1:0]  s_dat;
   logic              irq;

   int                slv_delay [NS];
   logic [31:0]       slv_data  [NS];
   int                scnt      [NS];

   logic [32:0]       exp_q [$];   // {check_data, data}
   logic [32:0]       exp_e;
   int                n_checks = 0;
   int                n_errors = 0;

   always #5 clk = ~clk;

   wb_slave_mux #(
      .N_SLAVES       (NS),
      .TIMEOUT_CYCLES (8)
   ) dut (
      .wb_clk_i  (clk),
      .wb_rst_i  (rst),
      .wbs_cyc_i (cyc),
      .wbs_stb_i (stb),
      .wbs_we_i  (we),
      .wbs_sel_i (sel),
      .wbs_adr_i (adr),
      .wbs_dat_i (wdat),
      .wbs_ack_o (ack),
      .wbs_dat_o (rdat),
      .s_cyc_o   (s_cyc),
      .s_stb_o   (s_stb),
      .s_ack_i   (s_ack),
      .s_dat_i   (s_dat),
      .s_irq_i   (s_irq),
      .irq_o     (irq)
   );

   // Slave model: ack after slv_delay cycles of strobe; negative = never.
   always @(posedge clk) begin
      for (int i = 0; i < NS; i++) scnt[i] <= s_stb[i] ? scnt[i] + 1 : 0;
   end

   always_comb begin
      s_ack = '0;
      s_dat = '0;
      for (int i = 0; i < NS; i++) begin
         s_dat[32*i +: 32] = slv_data[i];
         if (s_stb[i] && slv_delay[i] >= 0 && scnt[i] == slv_delay[i]) s_ack[i] = 1'b1;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Scoreboard consumer: every ack must have been announced.
   always @(negedge clk) begin
      if (ack) begin
         check("ack_expected", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) begin
            exp_e = exp_q.pop_front();
            if (exp_e[32]) check("ack_data", rdat, exp_e[31:0]);
         end
      end
   end

   // One master transaction. Cycle 0 is the cycle the strobe is first high.
   task automatic wb_xfer(input logic [31:0] a, input logic w, input logic [31:0] d,
                          input logic [3:0] sl, input logic chk, input logic [31:0] exp_d,
                          input logic [3:0] irq_set, output int lat,
                          output logic [3:0] stb_c1, output logic [3:0] stb_ack);
      exp_q.push_back({chk, exp_d});
      @(posedge clk); #1;
      cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = sl;
      s_irq = s_irq | irq_set;
      lat = -1; stb_c1 = '0; stb_ack = '1;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (c == 1) stb_c1 = s_stb;
         if (ack) begin
            lat = c;
            stb_ack = s_stb;
            break;
         end
      end
      @(posedge clk); #1;
      cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0;
      if (lat < 0 && exp_q.size() != 0) void'(exp_q.pop_back());
   endtask

   task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp_d,
                     input int exp_lat);
      int lat; logic [3:0] s1, sa;
      wb_xfer(a, 1'b0, 32'd0, 4'hF, 1'b1, exp_d, 4'h0, lat, s1, sa);
      check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
   endtask

   task automatic csr_rd(input string tag, input logic [3:0] off, input logic [31:0] exp_d);
      rd(tag, 32'h30FF_F000 | 32'(off), exp_d, 1);
   endtask

   task automatic csr_wr(input string tag, input logic [3:0] off, input logic [31:0] d,
                         input logic [3:0] sl, input logic [3:0] irq_set);
      int lat; logic [3:0] s1, sa;
      wb_xfer(32'h30FF_F000 | 32'(off), 1'b1, d, sl, 1'b0, 32'd0, irq_set, lat, s1, sa);
      check({tag, "_lat"}, 32'(lat), 32'd1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat; logic [3:0] s1, sa;
      rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0;
      adr = 32'd0; wdat = 32'd0; s_irq = '0;
      slv_delay = '{0, 0, 0, 0};
      slv_data  = '{32'hA0A0_0000, 32'h1234_5678, 32'h2222_2222, 32'h3333_3333};
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("rst_ack",  32'(ack),   32'd0);
      check("rst_dat",  rdat,       32'd0);
      check("rst_cyc",  32'(s_cyc), 32'd0);
      check("rst_stb",  32'(s_stb), 32'd0);
      check("rst_irq",  32'(irq),   32'd0);

      // Zero-wait read of slave 1
      wb_xfer(32'h3100_0004, 1'b0, 32'd0, 4'hF, 1'b1, 32'h1234_5678, 4'h0, lat, s1, sa);
      check("s1_lat", 32'(lat), 32'd2);
      check("s1_stb_c1", 32'(s1), 32'h2);
      csr_rd("status_idx1", 4'h0, 32'h0000_0100);

      // Wait-stated slave 3, then slave 0
      slv_delay[3] = 3;
      rd("s3", 32'h3300_0008, 32'h3333_3333, 5);
      rd("s0", 32'h3000_0000, 32'hA0A0_0000, 2);

      // Unmapped access
      rd("unmapped", 32'h3400_0000, 32'hBAD0_ADD0, 1);
      csr_rd("status_unm", 4'h0, 32'h0000_0001);
      csr_rd("erraddr_unm", 4'h4, 32'h3400_0000);
      csr_wr("w1c_unm", 4'h0, 32'h1, 4'hF, 4'h0);
      csr_rd("status_clr", 4'h0, 32'h0000_0000);
      csr_wr("mask_partial", 4'h8, 32'hF, 4'h3, 4'h0);
      csr_rd("mask_partial_rd", 4'h8, 32'h0);
      csr_rd("csr_other_off", 4'h1, 32'h0);

      // Timeout on slave 2
      slv_delay[2] = -1;
      wb_xfer(32'h3200_0010, 1'b0, 32'd0, 4'hF, 1'b1, 32'hDEAD_DEAD, 4'h0, lat, s1, sa);
      check("to_lat", 32'(lat), 32'd9);
      check("to_stb_at_ack", 32'(sa), 32'd0);
      csr_rd("status_to", 4'h0, 32'h0000_0202);
      csr_rd("erraddr_to", 4'h4, 32'h3200_0010);
      csr_wr("w1c_to", 4'h0, 32'h2, 4'hF, 4'h0);
      csr_rd("status_to_clr", 4'h0, 32'h0000_0200);

      // IRQ aggregation
      csr_wr("mask_wr", 4'h8, 32'h5, 4'hF, 4'h0);
      csr_rd("mask_rd", 4'h8, 32'h5);
      @(posedge clk); #1; s_irq[2] = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("irq_e1", 32'(irq), 32'd0);
      @(negedge clk);
      check("irq_e2", 32'(irq), 32'd1);
      @(posedge clk); #1; s_irq[2] = 1'b0; s_irq[1] = 1'b1;
      @(posedge clk); #1; s_irq[1] = 1'b0;
      csr_rd("pend_6", 4'hC, 32'h6);
      check("irq_on", 32'(irq), 32'd1);
      csr_wr("pend_w1c4", 4'hC, 32'h4, 4'hF, 4'h0);
      repeat (2) @(negedge clk);
      check("irq_off", 32'(irq), 32'd0);
      csr_rd("pend_2", 4'hC, 32'h2);
      csr_wr("pend_race", 4'hC, 32'h4, 4'hF, 4'h4);
      csr_rd("pend_race_rd", 4'hC, 32'h6);
      @(posedge clk); #1; s_irq[2] = 1'b0;

      // Reset while forwarding
      slv_delay[3] = -1;
      @(posedge clk); #1;
      cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h3300_0000; sel = 4'hF;
      @(negedge clk);
      @(negedge clk);
      check("rst_fwd_pre", 32'(s_stb), 32'h8);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("rst_fwd_stb", 32'(s_stb), 32'd0);
      check("rst_fwd_cyc", 32'(s_cyc), 32'd0);
      @(posedge clk); #1; cyc = 1'b0; stb = 1'b0;
      @(negedge clk); rst = 1'b0;
      repeat (12) @(negedge clk);
      check("rst_fwd_irq", 32'(irq), 32'd0);
      csr_rd("rst_mask", 4'h8, 32'h0);
      csr_rd("rst_pend", 4'hC, 32'h0);
      rd("post_rst", 32'h3100_0000, 32'h1234_5678, 2);

      // Master abort in FWD cycle 3
      @(posedge clk); #1;
      cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h3300_0004; sel = 4'hF;
      repeat (3) @(posedge clk);
      #1; cyc = 1'b0; stb = 1'b0;
      repeat (15) @(negedge clk);
      check("abort_stb", 32'(s_stb), 32'd0);
      csr_rd("abort_status", 4'h0, 32'h0000_0300);

      repeat (2) @(negedge clk);
      check("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/wb_slave_mux.md
# wb_slave_mux

Parametrised Wishbone slave-side interconnect for the user project area: decodes the Caravel master bus into `N_SLAVES` address windows and forwards cycles to one slave at a time. Adds, beyond fixed two-way decode:
- registered, one-outstanding forwarding,
- a default-slave error response for unmapped addresses,
- a per-transaction ack timeout,
- a CSR window with sticky error status and masked, edge-latched IRQ aggregation onto one `user_irq` line.

Sits between the wrapper's Wishbone ports and the accelerator macros. `we/sel/dat/adr` are broadcast to slaves by the wrapper.

## Interface
- `N_SLAVES`, 4: number of slave windows (1..8).
- `BASE_ADDRS`, {32'h3300_0000, 32'h3200_0000, 32'h3100_0000, 32'h3000_0000}: packed bases; slave i = bits [32i+31:32i].
- `ADDR_MASK`, 32'hFFFF_F000: window mask applied to address and every base.
- `CSR_BASE`, 32'h30FF_F000: internal CSR window, same mask; takes precedence over slaves.
- `TIMEOUT_CYCLES`, 255: max cycles waiting for slave ack (1..65535).
- `wb_clk_i  in  1  sole clock`
- `wb_rst_i  in  1  reset, asynchronous, active-high`
- `wbs_cyc_i / wbs_stb_i / wbs_we_i  in  1  master cycle, strobe, write`
- `wbs_sel_i  in  4  byte selects (CSR writes honour only the full-word case)`
- `wbs_adr_i / wbs_dat_i  in  32  master address, write data`
- `wbs_ack_o  out  1  registered ack to master`
- `wbs_dat_o  out  32  registered read data`
- `s_cyc_o / s_stb_o  out  N_SLAVES  one-hot gated cycle/strobe`
- `s_ack_i  in  N_SLAVES  slave acks`
- `s_dat_i  in  32*N_SLAVES  packed slave read data`
- `s_irq_i  in  N_SLAVES  level IRQs from slaves`
- `irq_o  out  1  OR of pending & mask`

## Operation
- FSM states: IDLE, FWD, ACK.
- IDLE, cyc&stb:
  - CSR hit: perform access, go ACK.
  - Else lowest-index matching slave: latch index `idx`, go FWD.
  - No match: set STATUS.unmapped, ERR_ADDR=adr, go ACK with data 32'hBAD0_ADD0.
- FWD:
  - `s_cyc_o[idx]=s_stb_o[idx]=1`, others 0; counter increments from 0.
  - `s_ack_i[idx]`: capture `s_dat_i[idx]`, go ACK.
  - Else counter == TIMEOUT_CYCLES-1: set STATUS.timeout, ERR_ADDR=latched adr, data 32'hDEAD_DEAD, go ACK.
  - Acks on non-selected slaves are ignored.
- ACK: `wbs_ack_o=1` for exactly one cycle with captured data; slave strobes 0; go IDLE.
- Master dropping cyc in FWD: abort, go IDLE, no ack, no error flag.
- CSRs (offset = adr[3:0]; other offsets read 0, writes ignored, still acked):
  - 0x0 STATUS: [0] unmapped, [1] timeout (sticky, W1C), [10:8] last selected idx (RO).
  - 0x4 ERR_ADDR: RO.
  - 0x8 IRQ_MASK: RW, [N_SLAVES-1:0].
  - 0xC IRQ_PEND: set on rising edge of `s_irq_i[i]`, W1C. Set wins over simultaneous clear.
- `irq_o` is registered `|(IRQ_PEND & IRQ_MASK)`.
- Write data for CSRs comes from `wbs_dat_i` when `wbs_sel_i==4'hF`; partial-sel writes acked, ignored.

## Timing
- Reset values: state IDLE, `wbs_ack_o=0`, `wbs_dat_o=0`, all `s_cyc_o/s_stb_o=0`, `irq_o=0`; STATUS, ERR_ADDR, MASK, PEND, IRQ edge flops = 0.
- Reset asserted mid-FWD: strobes drop asynchronously, no ack issued.
- Master stb at cycle 0:
  - Slave strobe asserts cycle 1.
  - Zero-wait slave ack in cycle 1 gives `wbs_ack_o` in cycle 2.
  - Slave acking in cycle k gives `wbs_ack_o` in cycle k+1.
- CSR/unmapped: ack in cycle 1.
- Timeout: `wbs_ack_o` in cycle TIMEOUT_CYCLES+1.
- Master holding stb in the cycle after ack: treated as a new request; the Caravel master drops stb after ack, so this is not expected.
- IRQ: `s_irq_i` rising at edge E sets PEND at E+1; `irq_o` at E+2.

## Test plan
- Read slave 1 (0x3100_0004), zero-wait, `s_dat_i` slice=32'h1234_5678 -> only `s_stb_o[1]` high in cycle 1; `wbs_ack_o`=1 in cycle 2 with 32'h1234_5678; STATUS[10:8]=1.
- Read 0x3400_0000 -> ack in cycle 1, data 32'hBAD0_ADD0; STATUS=0x1; ERR_ADDR=0x3400_0000. Write STATUS=0x1 -> reads 0.
- Slave 2 never acks, TIMEOUT_CYCLES=8 -> ack at cycle 9, data 32'hDEAD_DEAD, STATUS[1]=1, `s_stb_o` low from cycle 9.
- MASK=0x5; pulse `s_irq_i[2]`, then `s_irq_i[1]` -> PEND=0x6, `irq_o`=1. W1C 0x4 -> `irq_o`=0. New edge on irq 2 coincident with W1C 0x4 -> PEND bit 2 stays 1.
- Assert `wb_rst_i` during FWD -> strobes 0 immediately, no `wbs_ack_o`. Next read completes normally.
- Master drops cyc in FWD cycle 3 -> IDLE, no ack, STATUS unchanged.
